lsu_mem_if: RTL and testbench

//  Load/store unit between the decoder/ALU and the data-memory bus. Consumes the decoder's MemWrite/MemRead

---
 rtl/lsu_mem_if_pkg.sv | 62 ++++++
 rtl/lsu_mem_if_align.sv | 61 ++++++
 rtl/lsu_mem_if.sv | 141 ++++++++++++++
 tb/tb_lsu_mem_if.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_if_pkg.sv
// rtl/lsu_mem_if_pkg.sv - shared memory-op codes, LSU state encodings and op decode
package lsu_mem_if_pkg;

  // Store codes driven by the decoder on MemWrite
  localparam logic [1:0] MEM_NONE_W = 2'b00;
  localparam logic [1:0] MEM_SW     = 2'b01;
  localparam logic [1:0] MEM_SH     = 2'b10;
  localparam logic [1:0] MEM_SB     = 2'b11;

  // Load codes driven by the decoder on MemRead; 110/111 are illegal
  localparam logic [2:0] MEM_NONE_R = 3'b000;
  localparam logic [2:0] MEM_LW     = 3'b001;
  localparam logic [2:0] MEM_LH     = 3'b010;
  localparam logic [2:0] MEM_LHU    = 3'b011;
  localparam logic [2:0] MEM_LB     = 3'b100;
  localparam logic [2:0] MEM_LBU    = 3'b101;

  // LSU FSM state encodings
  localparam logic [2:0] LSU_IDLE = 3'd0;
  localparam logic [2:0] LSU_REQ  = 3'd1;
  localparam logic [2:0] LSU_WAIT = 3'd2;
  localparam logic [2:0] LSU_DONE = 3'd3;
  localparam logic [2:0] LSU_ERR  = 3'd4;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      load;
    mem_size_e size;
    logic      unsgn;
  } mem_op_t;

  // Collapse the two decoder codes into direction, access size and extension kind.
  // Conflicting or illegal codes are caught separately; this only picks a size.
  function automatic mem_op_t decode_op(input logic [1:0] mem_write, input logic [2:0] mem_read);
    mem_op_t op;
    op.load  = (mem_read != MEM_NONE_R);
    op.size  = SZ_W;
    op.unsgn = 1'b0;
    if (op.load) begin
      case (mem_read)
        MEM_LH:  op.size = SZ_H;
        MEM_LHU: begin op.size = SZ_H; op.unsgn = 1'b1; end
        MEM_LB:  op.size = SZ_B;
        MEM_LBU: begin op.size = SZ_B; op.unsgn = 1'b1; end
        default: op.size = SZ_W;
      endcase
    end else begin
      case (mem_write)
        MEM_SH:  op.size = SZ_H;
        MEM_SB:  op.size = SZ_B;
        default: op.size = SZ_W;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/lsu_mem_if_align.sv
// rtl/lsu_mem_if_align.sv - byte-lane steering for stores and load extraction/extension
module lsu_mem_if_align
  import lsu_mem_if_pkg::*;
(
  input  mem_size_e   req_size,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  input  mem_size_e   rsp_size,
  input  logic        rsp_unsgn,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata_ext
);

  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  // Request side: byte enables, lane-replicated store data and alignment check
  always_comb begin
    be         = 4'b0000;
    wdata_rep  = 32'h0;
    misaligned = 1'b0;
    case (req_size)
      SZ_W: begin
        be         = 4'b1111;
        wdata_rep  = req_wdata;
        misaligned = (req_off != 2'b00);
      end
      SZ_H: begin
        be         = 4'b0011 << {req_off[1], 1'b0};
        wdata_rep  = {2{req_wdata[15:0]}};
        misaligned = req_off[0];
      end
      default: begin
        be         = 4'b0001 << req_off;
        wdata_rep  = {4{req_wdata[7:0]}};
        misaligned = 1'b0;
      end
    endcase
  end

  // Response side: pick the addressed lane and sign- or zero-extend it
  always_comb begin
    half_lane = rsp_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (rsp_off)
      2'd0:    byte_lane = bus_rdata[7:0];
      2'd1:    byte_lane = bus_rdata[15:8];
      2'd2:    byte_lane = bus_rdata[23:16];
      default: byte_lane = bus_rdata[31:24];
    endcase
    case (rsp_size)
      SZ_W:    rdata_ext = bus_rdata;
      SZ_H:    rdata_ext = {{16{half_lane[15] & ~rsp_unsgn}}, half_lane};
      default: rdata_ext = {{24{byte_lane[7] & ~rsp_unsgn}}, byte_lane};
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - load/store unit FSM bridging decoder/ALU to the data-memory bus
module lsu_mem_if
  import lsu_mem_if_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MemWrite,
  input  logic [2:0]  MemRead,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  // Last counter value before giving up; unused when TIMEOUT is 0
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [TO_W-1:0] cnt;

  mem_op_t     cur_op;
  mem_op_t     op_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic [3:0]  be_now;
  logic [31:0] wdata_now;
  logic        mis_now;
  logic [31:0] rdata_ext;

  logic access;
  logic conflict;
  logic idle;
  logic accept;
  logic timed_out;

  assign cur_op   = decode_op(MemWrite, MemRead);
  assign access   = (MemWrite != MEM_NONE_W) || (MemRead != MEM_NONE_R);
  assign conflict = ((MemWrite != MEM_NONE_W) && (MemRead != MEM_NONE_R)) || (MemRead[2:1] == 2'b11);
  assign idle     = (state == LSU_IDLE);
  assign accept   = idle && access && !conflict && !mis_now;
  assign timed_out = (TIMEOUT != 0) && (cnt == TO_LAST);

  // Store lanes come from the live inputs; load extraction uses the latched access
  lsu_mem_if_align u_align (
    .req_size   (cur_op.size),
    .req_off    (addr[1:0]),
    .req_wdata  (wdata),
    .be         (be_now),
    .wdata_rep  (wdata_now),
    .misaligned (mis_now),
    .rsp_size   (op_q.size),
    .rsp_unsgn  (op_q.unsgn),
    .rsp_off    (addr_q[1:0]),
    .bus_rdata  (bus_rdata),
    .rdata_ext  (rdata_ext)
  );

  // Next-state logic; a grant or read response in the last counted cycle still wins over the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: begin
        if (access) begin
          if (conflict)      state_nxt = LSU_ERR;
          else if (!mis_now) state_nxt = LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (bus_gnt)        state_nxt = op_q.load ? LSU_WAIT : LSU_DONE;
        else if (timed_out) state_nxt = LSU_ERR;
      end
      LSU_WAIT: begin
        if (bus_rvalid)     state_nxt = LSU_DONE;
        else if (timed_out) state_nxt = LSU_ERR;
      end
      default: state_nxt = LSU_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight access
  always_ff @(posedge clk) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_nxt;
  end

  // Capture the access when it is accepted so the bus sees stable values
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= 32'h0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
    end else if (accept) begin
      op_q    <= cur_op;
      addr_q  <= addr;
      be_q    <= be_now;
      wdata_q <= wdata_now;
    end
  end

  // Timeout counter: cleared on entry to REQ, counts every REQ/WAIT cycle
  always_ff @(posedge clk) begin
    if (rst)                                         cnt <= '0;
    else if (accept)                                 cnt <= '0;
    else if (state == LSU_REQ || state == LSU_WAIT)  cnt <= cnt + 1'b1;
  end

  // Load result register; only a response seen in WAIT updates it
  always_ff @(posedge clk) begin
    if (rst)                                     rdata <= 32'h0;
    else if (state == LSU_WAIT && bus_rvalid)    rdata <= rdata_ext;
  end

  assign stall     = accept || (state == LSU_REQ) || (state == LSU_WAIT);
  assign done      = (state == LSU_DONE);
  assign bus_err   = (state == LSU_ERR);
  assign misalign  = idle && access && !conflict && mis_now;
  assign bus_req   = (state == LSU_REQ);
  assign bus_we    = bus_req && !op_q.load;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_be    = bus_req ? be_q : 4'b0000;
  assign bus_wdata = bus_we ? wdata_q : 32'h0;

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb/tb_lsu_mem_if.sv - directed self-checking bench for lsu_mem_if
module tb_lsu_mem_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  MemWrite;
  logic [2:0]  MemRead;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  int          n_stall, n_done, n_err, n_mis, n_req, n_leak, term_cyc;
  logic [31:0] cap_addr, cap_wdata, rdata_done;
  logic [3:0]  cap_be;
  logic        cap_we;

  always #5 clk = ~clk;

  lsu_mem_if #(.TIMEOUT(4), .TO_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One core access with a scripted bus: grant after gnt_dly REQ cycles (-1 never),
  // read data rv_dly cycles after the grant. Runs two idle cycles past the end.
  task automatic run_access(input logic [1:0] mw, input logic [2:0] mr, input logic [31:0] a,
                            input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                            input logic [31:0] rd);
    int gnt_cyc;
    int req_seen;
    n_stall = 0; n_done = 0; n_err = 0; n_mis = 0; n_req = 0; n_leak = 0; term_cyc = -1;
    cap_addr = 0; cap_wdata = 0; cap_be = 0; cap_we = 0; rdata_done = 0;
    gnt_cyc = -1; req_seen = 0;
    MemWrite = mw; MemRead = mr; addr = a; wdata = wd;
    for (int c = 0; c < 40; c++) begin
      bus_gnt    = bus_req && (req_seen == gnt_dly);
      bus_rvalid = (gnt_cyc >= 0) && (c == gnt_cyc + rv_dly);
      bus_rdata  = bus_rvalid ? rd : 32'h0;
      @(negedge clk);
      if (bus_req) begin
        if (n_req == 0) begin
          cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata; cap_we = bus_we;
        end
        n_req++;
        req_seen++;
      end
      if (bus_gnt) gnt_cyc = c;
      if (!bus_req && (bus_we || bus_be != 0 || bus_wdata != 0)) n_leak++;
      if (stall) n_stall++;
      if (done) begin n_done++; rdata_done = rdata; end
      if (bus_err) n_err++;
      if (misalign) n_mis++;
      if ((done || bus_err || misalign) && term_cyc < 0) term_cyc = c;
      @(posedge clk); #1;
      if (term_cyc >= 0) begin
        MemWrite = 2'b00; MemRead = 3'b000; addr = 32'h0; wdata = 32'h0;
        if (c >= term_cyc + 2) break;
      end
    end
    if (term_cyc < 0) $display("FAIL no_end: got 0x%08h expected 0x%08h", 0, 1);
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got 0x%08h expected 0x%08h", 1, 0);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; MemWrite = 0; MemRead = 0; addr = 0; wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall",   32'(stall),    0);
    check("rst_done",    32'(done),     0);
    check("rst_mis",     32'(misalign), 0);
    check("rst_err",     32'(bus_err),  0);
    check("rst_req",     32'(bus_req),  0);
    check("rst_be",      32'(bus_be),   0);
    check("rst_rdata",   rdata,         0);
    @(posedge clk); #1;

    // SB at byte 3
    run_access(2'b11, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, -1, 0);
    check("sb_be",    32'(cap_be), 32'h8);
    check("sb_addr",  cap_addr,    32'h0000_1000);
    check("sb_wdata", cap_wdata,   32'hABAB_ABAB);
    check("sb_we",    32'(cap_we), 1);
    check("sb_done",  n_done,      1);
    check("sb_stall", n_stall,     2);
    check("sb_leak",  n_leak,      0);

    // SH upper half
    run_access(2'b10, 3'b000, 32'h0000_1002, 32'h5555_1234, 0, -1, 0);
    check("sh_be",    32'(cap_be), 32'hC);
    check("sh_wdata", cap_wdata,   32'h1234_1234);
    check("sh_done",  n_done,      1);

    // LH / LHU upper half, data two cycles after grant
    run_access(2'b00, 3'b010, 32'h0000_2002, 0, 0, 2, 32'h8001_7F00);
    check("lh_rdata", rdata_done,  32'hFFFF_8001);
    check("lh_stall", n_stall,     4);
    check("lh_we",    32'(cap_we), 0);
    check("lh_addr",  cap_addr,    32'h0000_2000);
    check("lh_leak",  n_leak,      0);
    run_access(2'b00, 3'b011, 32'h0000_2002, 0, 0, 2, 32'h8001_7F00);
    check("lhu_rdata", rdata_done, 32'h0000_8001);

    // Byte loads and a word load with zero-wait response
    run_access(2'b00, 3'b100, 32'h0000_2001, 0, 0, 1, 32'h8001_7F00);
    check("lb1_rdata",  rdata_done, 32'h0000_007F);
    run_access(2'b00, 3'b100, 32'h0000_2003, 0, 0, 1, 32'h8001_7F00);
    check("lb3_rdata",  rdata_done, 32'hFFFF_FF80);
    run_access(2'b00, 3'b101, 32'h0000_2003, 0, 0, 1, 32'h8001_7F00);
    check("lbu3_rdata", rdata_done, 32'h0000_0080);
    run_access(2'b00, 3'b001, 32'h0000_2000, 0, 0, 1, 32'h8001_7F00);
    check("lw_rdata",   rdata_done, 32'h8001_7F00);
    check("lw_stall",   n_stall,    3);
    check("lw_be",      32'(cap_be), 32'hF);

    // Misaligned word and half
    run_access(2'b00, 3'b001, 32'h0000_3001, 0, 0, 1, 0);
    check("lw_mis",      n_mis,    1);
    check("lw_mis_cyc",  term_cyc, 0);
    check("lw_mis_req",  n_req,    0);
    check("lw_mis_stl",  n_stall,  0);
    check("lw_mis_hold", rdata,    32'h8001_7F00);
    run_access(2'b10, 3'b000, 32'h0000_3001, 32'h1, 0, -1, 0);
    check("sh_mis",      n_mis,    1);
    check("sh_mis_req",  n_req,    0);
    check("sh_mis_stl",  n_stall,  0);

    // Timeout: no grant, TIMEOUT=4
    run_access(2'b00, 3'b001, 32'h0000_3000, 0, -1, 1, 0);
    check("to_cyc",   term_cyc, 5);
    check("to_err",   n_err,    1);
    check("to_done",  n_done,   0);
    check("to_req",   n_req,    4);
    check("to_stall", n_stall,  5);
    check("to_rdata", rdata,    32'h8001_7F00);

    // Grant in the last counted cycle beats the timeout
    run_access(2'b01, 3'b000, 32'h0000_3004, 32'hDEAD_BEEF, 3, -1, 0);
    check("tob_cyc",  term_cyc,  5);
    check("tob_done", n_done,    1);
    check("tob_err",  n_err,     0);
    check("tob_wd",   cap_wdata, 32'hDEAD_BEEF);

    // Conflicting and illegal codes
    run_access(2'b01, 3'b001, 32'h0000_5000, 32'h1, 0, 1, 0);
    check("cf_err",   n_err,    1);
    check("cf_cyc",   term_cyc, 1);
    check("cf_req",   n_req,    0);
    check("cf_stall", n_stall,  0);
    run_access(2'b00, 3'b110, 32'h0000_5000, 0, 0, 1, 0);
    check("il_err",   n_err,    1);
    check("il_req",   n_req,    0);

    // Reset during WAIT of an LB, then a late response
    MemRead = 3'b100; addr = 32'h0000_4001;
    @(negedge clk);
    check("rw_accept", 32'(stall), 1);
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(negedge clk);
    check("rw_req", 32'(bus_req), 1);
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    check("rw_wait", 32'(stall), 1);
    rst = 1'b1; MemRead = 3'b000; addr = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rw_req0",   32'(bus_req), 0);
    check("rw_stall0", 32'(stall),   0);
    check("rw_done0",  32'(done),    0);
    check("rw_rdata0", rdata,        0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    check("rw_late_done",  32'(done), 0);
    check("rw_late_rdata", rdata,     0);
    @(posedge clk); #1;
    run_access(2'b00, 3'b100, 32'h0000_4001, 0, 0, 1, 32'h0000_8000);
    check("rw_next_rdata", rdata_done, 32'hFFFF_FF80);
    check("rw_next_done",  n_done,     1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
